// File: rtl/temp_sample_sequencer.sv
// Sample sequencer for the temperature calculator: triggers ADC conversions,
// holds the calculator inputs stable, captures tempc and tracks alarm/timeout.
module temp_sample_sequencer #(
    parameter int unsigned PERIOD   = 1000,
    parameter int unsigned CALC_LAT = 2,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] RST_BASE = 32'd1,
    parameter logic [7:0]  RST_REF  = 8'd24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        force_sample,
    input  logic        cfg_load,
    input  logic [31:0] cfg_tc_base,
    input  logic [7:0]  cfg_tc_ref,
    input  logic [31:0] thr_hi,
    input  logic [31:0] thr_lo,
    input  logic        err_clr,
    output logic        adc_start,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    output logic [31:0] calc_tc_base,
    output logic [7:0]  calc_tc_ref,
    output logic [15:0] calc_adc_data,
    input  logic [31:0] calc_tempc,
    output logic        busy,
    output logic [31:0] temp_out,
    output logic        temp_valid,
    output logic        alarm,
    output logic        timeout_err,
    output logic [15:0] sample_cnt
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = $clog2(CALC_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ADC,
        CALC,
        CAPTURE
    } state_t;

    state_t      state_reg;
    logic [PW-1:0] period_cnt_reg;
    logic [TW-1:0] wait_cnt_reg;
    logic [CW-1:0] calc_cnt_reg;
    logic        force_pend_reg;
    logic        cfg_pend_reg;
    logic [31:0] stage_base_reg;
    logic [7:0]  stage_ref_reg;
    logic [31:0] calc_base_reg;
    logic [7:0]  calc_ref_reg;
    logic [15:0] calc_adc_reg;
    logic        adc_start_reg;
    logic        busy_reg;
    logic [31:0] temp_out_reg;
    logic        temp_valid_reg;
    logic        alarm_reg;
    logic        timeout_err_reg;
    logic [15:0] sample_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            period_cnt_reg  <= '0;
            wait_cnt_reg    <= '0;
            calc_cnt_reg    <= '0;
            force_pend_reg  <= 1'b0;
            cfg_pend_reg    <= 1'b0;
            stage_base_reg  <= RST_BASE;
            stage_ref_reg   <= RST_REF;
            calc_base_reg   <= RST_BASE;
            calc_ref_reg    <= RST_REF;
            calc_adc_reg    <= '0;
            adc_start_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            temp_out_reg    <= '0;
            temp_valid_reg  <= 1'b0;
            alarm_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
            sample_cnt_reg  <= '0;
        end else begin
            adc_start_reg  <= 1'b0;
            temp_valid_reg <= 1'b0;
            if (cfg_load) begin
                stage_base_reg <= cfg_tc_base;
                stage_ref_reg  <= cfg_tc_ref;
                cfg_pend_reg   <= 1'b1;
            end
            if (force_sample)
                force_pend_reg <= 1'b1;
            if (err_clr)
                timeout_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Config only moves into the calculator here, so a sample in flight never sees it change.
                    if (cfg_load) begin
                        calc_base_reg <= cfg_tc_base;
                        calc_ref_reg  <= cfg_tc_ref;
                        cfg_pend_reg  <= 1'b0;
                    end else if (cfg_pend_reg) begin
                        calc_base_reg <= stage_base_reg;
                        calc_ref_reg  <= stage_ref_reg;
                        cfg_pend_reg  <= 1'b0;
                    end
                    if (!enable) begin
                        period_cnt_reg <= '0;
                        force_pend_reg <= 1'b0;
                    end else if (period_cnt_reg == PW'(PERIOD - 1) || force_sample || force_pend_reg) begin
                        period_cnt_reg <= '0;
                        force_pend_reg <= 1'b0;
                        adc_start_reg  <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= START;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                    end
                end
                START: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT_ADC;
                end
                WAIT_ADC: begin
                    if (adc_valid) begin
                        calc_adc_reg <= adc_data;
                        calc_cnt_reg <= '0;
                        state_reg    <= CALC;
                    end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                CALC: begin
                    if (calc_cnt_reg == CW'(CALC_LAT - 1))
                        state_reg <= CAPTURE;
                    else
                        calc_cnt_reg <= calc_cnt_reg + 1'b1;
                end
                CAPTURE: begin
                    temp_out_reg   <= calc_tempc;
                    temp_valid_reg <= 1'b1;
                    sample_cnt_reg <= sample_cnt_reg + 16'd1;
                    if (calc_tempc >= thr_hi)
                        alarm_reg <= 1'b1;
                    else if (calc_tempc < thr_lo)
                        alarm_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign adc_start     = adc_start_reg;
    assign busy          = busy_reg;
    assign calc_tc_base  = calc_base_reg;
    assign calc_tc_ref   = calc_ref_reg;
    assign calc_adc_data = calc_adc_reg;
    assign temp_out      = temp_out_reg;
    assign temp_valid    = temp_valid_reg;
    assign alarm         = alarm_reg;
    assign timeout_err   = timeout_err_reg;
    assign sample_cnt    = sample_cnt_reg;

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// Bench for temp_sample_sequencer: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_temp_sample_sequencer;
    localparam int PERIOD   = 8;
    localparam int CALC_LAT = 2;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        force_sample = 1'b0;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_tc_base = 32'd0;
    logic [7:0]  cfg_tc_ref = 8'd0;
    logic [31:0] thr_hi = 32'd100;
    logic [31:0] thr_lo = 32'd90;
    logic        err_clr = 1'b0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = 16'd0;
    logic        adc_start, busy, temp_valid, alarm, timeout_err;
    logic [31:0] calc_tc_base, temp_out, calc_tempc;
    logic [7:0]  calc_tc_ref;
    logic [15:0] calc_adc_data, sample_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Stand-in calculator: tempc = adc_data + tc_base
    assign calc_tempc = {16'h0, calc_adc_data} + calc_tc_base;

    temp_sample_sequencer #(
        .PERIOD(PERIOD), .CALC_LAT(CALC_LAT), .TIMEOUT(TIMEOUT),
        .RST_BASE(32'd1), .RST_REF(8'd24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_sample(force_sample),
        .cfg_load(cfg_load), .cfg_tc_base(cfg_tc_base), .cfg_tc_ref(cfg_tc_ref),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .err_clr(err_clr),
        .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
        .calc_tc_base(calc_tc_base), .calc_tc_ref(calc_tc_ref),
        .calc_adc_data(calc_adc_data), .calc_tempc(calc_tempc),
        .busy(busy), .temp_out(temp_out), .temp_valid(temp_valid),
        .alarm(alarm), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a sample is described by its trigger and valid timestamps.
    logic        m_ok = 1'b0;
    logic        e_adc_start = 1'b0, e_busy = 1'b0, e_temp_valid = 1'b0;
    logic        e_alarm = 1'b0, e_err = 1'b0;
    logic [31:0] e_base = 32'd1, e_temp = 32'd0;
    logic [7:0]  e_ref = 8'd24;
    logic [15:0] e_adc = 16'd0, e_cnt = 16'd0;
    logic [31:0] st_base = 32'd0;
    logic [7:0]  st_ref = 8'd0;
    bit          st_pend = 1'b0, f_pend = 1'b0, in_flight = 1'b0;
    int          idle_elapsed = 0, t_trig = 0, t_valid = -1;

    always @(posedge clk) begin
        int c;
        logic [31:0] v;
        c = cyc;
        cyc++;
        e_adc_start = 1'b0;
        e_temp_valid = 1'b0;
        if (!rst_n) begin
            m_ok = 1'b1;
            e_busy = 1'b0; e_alarm = 1'b0; e_err = 1'b0; e_temp = 32'd0;
            e_adc = 16'd0; e_cnt = 16'd0; e_base = 32'd1; e_ref = 8'd24;
            st_pend = 1'b0; f_pend = 1'b0; in_flight = 1'b0; idle_elapsed = 0;
        end else begin
            if (cfg_load) begin st_base = cfg_tc_base; st_ref = cfg_tc_ref; st_pend = 1'b1; end
            if (force_sample) f_pend = 1'b1;
            if (err_clr) e_err = 1'b0;
            if (!in_flight) begin
                if (st_pend) begin e_base = st_base; e_ref = st_ref; st_pend = 1'b0; end
                if (!enable) begin
                    idle_elapsed = 0;
                    f_pend = 1'b0;
                end else if (idle_elapsed == PERIOD - 1 || f_pend) begin
                    in_flight = 1'b1; t_trig = c; t_valid = -1;
                    idle_elapsed = 0; f_pend = 1'b0;
                    e_adc_start = 1'b1; e_busy = 1'b1;
                end else begin
                    idle_elapsed++;
                end
            end else if (t_valid < 0) begin
                // Waiting window is cycles t_trig+2 .. t_trig+1+TIMEOUT
                if (c >= t_trig + 2) begin
                    if (adc_valid) begin
                        t_valid = c;
                        e_adc = adc_data;
                    end else if (c == t_trig + 1 + TIMEOUT) begin
                        e_err = 1'b1; in_flight = 1'b0; e_busy = 1'b0;
                    end
                end
            end else if (c == t_valid + CALC_LAT + 1) begin
                v = {16'h0, e_adc} + e_base;
                e_temp = v; e_temp_valid = 1'b1; e_cnt = e_cnt + 16'd1;
                if (v >= thr_hi) e_alarm = 1'b1;
                else if (v < thr_lo) e_alarm = 1'b0;
                in_flight = 1'b0; e_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("adc_start", 32'(adc_start), 32'(e_adc_start));
            check("busy", 32'(busy), 32'(e_busy));
            check("temp_valid", 32'(temp_valid), 32'(e_temp_valid));
            check("temp_out", temp_out, e_temp);
            check("alarm", 32'(alarm), 32'(e_alarm));
            check("timeout_err", 32'(timeout_err), 32'(e_err));
            check("sample_cnt", 32'(sample_cnt), 32'(e_cnt));
            check("calc_tc_base", calc_tc_base, e_base);
            check("calc_tc_ref", 32'(calc_tc_ref), 32'(e_ref));
            check("calc_adc_data", 32'(calc_adc_data), 32'(e_adc));
        end
    end

    task automatic force_one();
        enable = 1'b1;
        force_sample = 1'b1;
        @(negedge clk);
        force_sample = 1'b0;
        enable = 1'b0;
    endtask

    task automatic wait_for_start(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (adc_start) begin at = cyc; break; end
            @(negedge clk);
        end
        if (at < 0) check("adc_start_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_for_tv(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (temp_valid) begin at = cyc; break; end
            @(negedge clk);
        end
        if (at < 0) check("temp_valid_wait", 32'd0, 32'd1);
    endtask

    // adc_valid asserted 'delay' cycles after the current one
    task automatic respond(input int delay, input logic [15:0] data);
        repeat (delay) @(negedge clk);
        adc_valid = 1'b1;
        adc_data = data;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    initial begin
        int s, t, base, n;
        int hv[4];
        int ha[4];
        hv = '{95, 100, 95, 89};
        ha = '{0, 1, 1, 0};

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_temp_out", temp_out, 32'd0);
        check("rst_base", calc_tc_base, 32'd1);
        check("rst_ref", 32'(calc_tc_ref), 32'd24);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);

        // Automatic sample, PERIOD=8
        rst_n = 1'b1;
        enable = 1'b1;
        base = cyc;
        wait_for_start(s);
        check("auto_start_cycle", 32'(s - base), 32'd8);
        respond(3, 16'h3081);
        wait_for_tv(t);
        enable = 1'b0;
        check("auto_latency", 32'(t - s), 32'd7);
        check("auto_temp", temp_out, 32'h0000_3082);
        check("auto_cnt", 32'(sample_cnt), 32'd1);

        // Timeout, with err_clr on the final waiting cycle
        force_one();
        wait_for_start(s);
        repeat (TIMEOUT) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_temp_kept", temp_out, 32'h0000_3082);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_clr", 32'(timeout_err), 32'd0);

        // adc_valid on the last allowed cycle still succeeds
        force_one();
        wait_for_start(s);
        respond(TIMEOUT, 16'h0010);
        wait_for_tv(t);
        check("last_cycle_latency", 32'(t - s), 32'(TIMEOUT + 4));
        check("last_cycle_temp", temp_out, 32'h0000_0011);
        check("last_cycle_err", 32'(timeout_err), 32'd0);

        // Hysteresis after a fresh reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            force_one();
            wait_for_start(s);
            respond(2, 16'(hv[i] - 1));
            wait_for_tv(t);
            check("hyst_temp", temp_out, 32'(hv[i]));
            check("hyst_alarm", 32'(alarm), 32'(ha[i]));
        end

        // force_sample during WAIT_ADC collapses into one extra sample
        enable = 1'b1;
        force_sample = 1'b1;
        @(negedge clk);
        force_sample = 1'b0;
        wait_for_start(s);
        @(negedge clk); force_sample = 1'b1;
        @(negedge clk); force_sample = 1'b0;
        @(negedge clk); force_sample = 1'b1;
        @(negedge clk); force_sample = 1'b0;
        respond(1, 16'd20);
        wait_for_tv(t);
        @(negedge clk);
        check("pend_restart", 32'(adc_start), 32'd1);
        enable = 1'b0;
        respond(2, 16'd30);
        wait_for_tv(t);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += 32'(adc_start);
        end
        check("pend_no_extra", 32'(n), 32'd0);
        check("pend_cnt", 32'(sample_cnt), 32'd6);

        // Config deferral: cfg_load during CALC
        force_one();
        wait_for_start(s);
        respond(1, 16'd50);
        cfg_load = 1'b1; cfg_tc_base = 32'd5; cfg_tc_ref = 8'd30;
        @(negedge clk);
        cfg_load = 1'b0;
        wait_for_tv(t);
        check("cfg_hold_base", calc_tc_base, 32'd1);
        check("cfg_hold_ref", 32'(calc_tc_ref), 32'd24);
        check("cfg_hold_temp", temp_out, 32'd51);
        @(negedge clk);
        check("cfg_new_base", calc_tc_base, 32'd5);
        check("cfg_new_ref", 32'(calc_tc_ref), 32'd30);

        // cfg_load coincident with a trigger applies to this sample
        cfg_load = 1'b1; cfg_tc_base = 32'd7; cfg_tc_ref = 8'd40;
        force_one();
        cfg_load = 1'b0;
        check("cfg_trig_start", 32'(adc_start), 32'd1);
        check("cfg_trig_base", calc_tc_base, 32'd7);
        respond(1, 16'd100);
        wait_for_tv(t);
        check("cfg_trig_temp", temp_out, 32'd107);

        // Reset during CALC aborts the sample
        force_one();
        wait_for_start(s);
        respond(1, 16'd200);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += 32'(temp_valid);
        end
        check("abort_no_tv", 32'(n), 32'd0);
        check("abort_cnt", 32'(sample_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/temp_sample_sequencer.md
Name: temp_sample_sequencer

Overview:
Sequences the TemperatureCalculator datapath. It triggers ADC conversions periodically or on demand, and drives the calculator's tc_base, tc_ref and adc_data inputs from stable registers. After a fixed settling latency it captures tempc, flags over-temperature with hysteresis, and reports ADC timeouts. It sits between the ADC interface, the config registers and the calculator.

Parameters:
PERIOD, 1000, IDLE cycles between automatic samples (>=2)
CALC_LAT, 2, cycles calculator inputs are held before tempc is captured (>=1)
TIMEOUT, 64, max WAIT_ADC cycles before timeout (>=1)
RST_BASE, 32'd1, reset value of calc_tc_base
RST_REF, 8'd24, reset value of calc_tc_ref

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
enable  in  1  1 = automatic and forced sampling allowed
force_sample  in  1  pulse: sample now
cfg_load  in  1  pulse: stage cfg_tc_base/cfg_tc_ref
cfg_tc_base  in  32  new base
cfg_tc_ref  in  8  new reference
thr_hi  in  32  alarm set threshold (unsigned)
thr_lo  in  32  alarm clear threshold (unsigned)
err_clr  in  1  clears timeout_err
adc_start  out  1  one-cycle conversion request
adc_valid  in  1  conversion result valid
adc_data  in  16  conversion result
calc_tc_base  out  32  to calculator tc_base
calc_tc_ref  out  8  to calculator tc_ref
calc_adc_data  out  16  to calculator adc_data
calc_tempc  in  32  from calculator tempc (combinational)
busy  out  1  state != IDLE
temp_out  out  32  last captured temperature
temp_valid  out  1  one-cycle pulse on capture
alarm  out  1  over-temperature flag
timeout_err  out  1  sticky ADC timeout flag
sample_cnt  out  16  successful captures, wraps 16'hFFFF->0

Behaviour:
- Single clock clk; rst_n synchronous active-low. While rst_n=0 at an edge, state goes to IDLE and all counters and pending flags clear.
- Reset values: outputs 0, except calc_tc_base=RST_BASE and calc_tc_ref=RST_REF.
- Reset mid-operation aborts the sample with no capture and no error.
- States: IDLE, START, WAIT_ADC, CALC, CAPTURE.
- IDLE:
  - With enable=1, period counter increments each cycle.
  - Trigger when counter==PERIOD-1 or a force_sample pending/asserted. Trigger -> START and counter clears.
  - With enable=0, counter is held at 0 and triggers are ignored (pending force also cleared).
- force_sample outside IDLE sets a pending flag. It is serviced as a trigger in the first IDLE cycle if enable=1. Multiple pulses collapse to one.
- START (1 cycle): adc_start=1 -> WAIT_ADC. adc_valid is ignored in START.
- WAIT_ADC:
  - On adc_valid=1: latch adc_data into calc_adc_data, go to CALC.
  - Otherwise the wait counter increments. After TIMEOUT cycles without adc_valid, set timeout_err and return to IDLE. temp_out, alarm and sample_cnt are unchanged.
  - adc_valid on the final allowed cycle wins over timeout.
- CALC: held exactly CALC_LAT cycles, calculator inputs constant, then CAPTURE.
- CAPTURE (1 cycle):
  - temp_out<=calc_tempc; temp_valid=1 during the following cycle; sample_cnt+1.
  - Alarm update: set if value>=thr_hi; else clear if value<thr_lo; else hold.
  - Return to IDLE.
- Latency: adc_valid at cycle V -> temp_valid high at V+CALC_LAT+2. Trigger at T -> adc_start high at T+1.
- cfg_load stages cfg values into staging registers at the pulse cycle. Staged values transfer to calc_tc_base/calc_tc_ref on the first IDLE-state edge, so the calculator inputs never change outside IDLE.
  - cfg_load in IDLE: applied at the next edge.
  - cfg_load coincident with a trigger: applied at the same edge, so this sample uses the new config.
  - A second cfg_load before apply overwrites the staged values.
- err_clr clears timeout_err; a timeout in the same cycle wins (flag stays 1).
- thr_lo>thr_hi is not checked. Set has priority.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, calc_tc_base=1, calc_tc_ref=24, busy=0.
- Auto sample: PERIOD=8, enable=1, adc_valid 3 cycles after adc_start with adc_data=16'h3081, model tempc=adc_data+1 -> adc_start at cycle 8; temp_valid at V+4 with temp_out=32'h3082; sample_cnt=1.
- Timeout: force_sample, never assert adc_valid, TIMEOUT=64 -> timeout_err=1 after 64 WAIT_ADC cycles, then busy=0, temp_out unchanged. err_clr -> 0.
- Config deferral: cfg_load (base=5, ref=30) during CALC -> calc outputs unchanged until the IDLE edge, then 5/30.
- Hysteresis: thr_hi=100, thr_lo=90, captures 95,100,95,89 -> alarm 0,1,1,0.
- Boundaries:
  - force_sample during WAIT_ADC -> exactly one extra sample after return to IDLE.
  - rst_n=0 during CALC -> no temp_valid, sample_cnt=0.
